// File: rtl/fifo_ctrl.sv
// FIFO controller: drives addresses, strobes and write data for an external dual-port
// memory, and tracks occupancy, threshold flags, read-data valid and a sticky error.
module fifo_ctrl #(
  parameter int unsigned MEM_WIDTH  = 10,
  parameter int unsigned MEM_LENGTH = 8,
  parameter int unsigned AF_TH      = 6,
  parameter int unsigned AE_TH      = 2
) (
  input  logic                 clk,
  input  logic                 reset_L,
  input  logic                 push,
  input  logic                 pop,
  input  logic [MEM_WIDTH-1:0] data_in,
  output logic [MEM_WIDTH-1:0] fifo_Data_in,
  output logic [3:0]           write_addr,
  output logic [3:0]           read_addr,
  output logic                 write_enable,
  output logic                 read_enable,
  output logic                 full,
  output logic                 empty,
  output logic                 almost_full,
  output logic                 almost_empty,
  output logic [3:0]           count,
  output logic                 data_valid,
  output logic                 error
);

  localparam int unsigned PtrW = (MEM_LENGTH > 1) ? $clog2(MEM_LENGTH) : 1;

  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [3:0]      count_q, count_d;
  logic            error_q, error_d;
  logic            data_valid_q, data_valid_d;
  logic            push_ok, pop_ok;

  // Flags come from the registered count only, so they are reset values while reset_L is low.
  assign full         = (count_q == 4'(MEM_LENGTH));
  assign empty        = (count_q == 4'd0);
  assign almost_full  = (count_q >= 4'(AF_TH));
  assign almost_empty = (count_q <= 4'(AE_TH));

  // reset_L gates the strobes so the memory sees no access while reset is held.
  assign push_ok = push & ~full & reset_L;
  assign pop_ok  = pop & ~empty & reset_L;

  assign write_enable = push_ok;
  assign read_enable  = pop_ok;
  assign fifo_Data_in = data_in;
  assign write_addr   = 4'(wr_ptr_q);
  assign read_addr    = 4'(rd_ptr_q);
  assign count        = count_q;
  assign error        = error_q;
  assign data_valid   = data_valid_q;

  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    data_valid_d = pop_ok;
    error_d      = error_q | (push & full) | (pop & empty);

    // Depth is a power of two, so pointer wrap is the natural overflow.
    if (push_ok) wr_ptr_d = wr_ptr_q + PtrW'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + PtrW'(1);

    unique case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 4'd1;
      2'b01:   count_d = count_q - 4'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      error_q      <= 1'b0;
      data_valid_q <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      error_q      <= error_d;
      data_valid_q <= data_valid_d;
    end
  end

endmodule

// File: tb/tb_fifo_ctrl.sv
// Bench for fifo_ctrl: a queue-based reference model plus a behavioural memory, compared
// every cycle, with directed scenarios pinned by literal expectations and a random phase.
module tb_fifo_ctrl;

  localparam int W = 10;
  localparam int D = 8;

  logic         clk = 1'b0;
  logic         reset_L = 1'b0;
  logic         push = 1'b0;
  logic         pop = 1'b0;
  logic [W-1:0] data_in = '0;
  logic [W-1:0] fifo_Data_in;
  logic [3:0]   write_addr, read_addr, count;
  logic         write_enable, read_enable, full, empty, almost_full, almost_empty;
  logic         data_valid, error;

  fifo_ctrl #(
    .MEM_WIDTH (W),
    .MEM_LENGTH(D),
    .AF_TH     (6),
    .AE_TH     (2)
  ) dut (
    .clk         (clk),
    .reset_L     (reset_L),
    .push        (push),
    .pop         (pop),
    .data_in     (data_in),
    .fifo_Data_in(fifo_Data_in),
    .write_addr  (write_addr),
    .read_addr   (read_addr),
    .write_enable(write_enable),
    .read_enable (read_enable),
    .full        (full),
    .empty       (empty),
    .almost_full (almost_full),
    .almost_empty(almost_empty),
    .count       (count),
    .data_valid  (data_valid),
    .error       (error)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Memory that the controller drives: synchronous write, registered read.
  logic [W-1:0] mem [D];
  logic [W-1:0] rdata;
  always @(posedge clk) begin
    if (write_enable) mem[write_addr[2:0]] <= fifo_Data_in;
    if (read_enable)  rdata <= mem[read_addr[2:0]];
  end

  // Reference model: a queue of stored words plus counts of accepted pushes and pops.
  logic [W-1:0] mq[$];
  int           wr_n = 0;
  int           rd_n = 0;
  bit           m_err = 1'b0;
  bit           m_dv = 1'b0;
  logic [W-1:0] m_data = '0;

  always @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      mq.delete();
      wr_n  = 0;
      rd_n  = 0;
      m_err = 1'b0;
      m_dv  = 1'b0;
    end else begin
      bit wok, pok;
      wok   = push && (mq.size() < D);
      pok   = pop && (mq.size() > 0);
      m_err = m_err || (push && mq.size() == D) || (pop && mq.size() == 0);
      m_dv  = pok;
      if (pok) begin
        m_data = mq.pop_front();
        rd_n++;
      end
      if (wok) begin
        mq.push_back(data_in);
        wr_n++;
      end
    end
  end

  always @(negedge clk) begin
    #2;
    begin
      int n;
      n = mq.size();
      chk("m_count", count, n);
      chk("m_full", full, n == D);
      chk("m_empty", empty, n == 0);
      chk("m_afull", almost_full, n >= 6);
      chk("m_aempty", almost_empty, n <= 2);
      chk("m_error", error, m_err);
      chk("m_dvalid", data_valid, m_dv);
      chk("m_we", write_enable, reset_L && push && n < D);
      chk("m_re", read_enable, reset_L && pop && n > 0);
      chk("m_waddr", write_addr, wr_n % D);
      chk("m_raddr", read_addr, rd_n % D);
      chk("m_wdata", fifo_Data_in, data_in);
      if (m_dv) chk("m_rdata", rdata, m_data);
    end
  end

  task automatic drive(input bit p, input bit q, input logic [W-1:0] d);
    @(negedge clk);
    push    = p;
    pop     = q;
    data_in = d;
  endtask

  task automatic do_reset();
    @(negedge clk);
    push    = 1'b0;
    pop     = 1'b0;
    reset_L = 1'b0;
    @(negedge clk);
    reset_L = 1'b1;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    #1;
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_aempty", almost_empty, 1);
    chk("rst_full", full, 0);
    chk("rst_afull", almost_full, 0);
    chk("rst_error", error, 0);
    chk("rst_dvalid", data_valid, 0);
    reset_L = 1'b1;

    // Fill to full with 0x001..0x008.
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 1'b0, W'(i + 1));
      #1;
      chk("fill_waddr", write_addr, i);
      chk("fill_we", write_enable, 1);
      chk("fill_afull", almost_full, i >= 6);
      chk("fill_empty", empty, i == 0);
    end
    drive(1'b1, 1'b0, 10'h3ff);
    #1;
    chk("full_flag", full, 1);
    chk("full_count", count, 8);
    chk("full_err_pre", error, 0);
    chk("ovf_we", write_enable, 0);
    drive(1'b0, 1'b0, '0);
    #1;
    chk("ovf_err", error, 1);
    chk("ovf_count", count, 8);

    // Drain in order.
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, 1'b1, '0);
      #1;
      chk("drain_raddr", read_addr, i);
      chk("drain_re", read_enable, 1);
      chk("drain_dvalid", data_valid, i > 0);
      if (i > 0) chk("drain_rdata", rdata, i);
    end
    drive(1'b0, 1'b0, '0);
    #1;
    chk("drain_last_dv", data_valid, 1);
    chk("drain_last_data", rdata, 8);
    chk("drain_empty", empty, 1);
    chk("drain_count", count, 0);

    // Pop on empty.
    do_reset();
    drive(1'b0, 1'b1, '0);
    #1;
    chk("udf_re", read_enable, 0);
    drive(1'b0, 1'b0, '0);
    #1;
    chk("udf_count", count, 0);
    chk("udf_err", error, 1);
    chk("udf_dvalid", data_valid, 0);

    // Simultaneous push and pop at count 3.
    do_reset();
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, W'(10'h11 + i));
    drive(1'b1, 1'b1, 10'h14);
    #1;
    chk("both_we", write_enable, 1);
    chk("both_re", read_enable, 1);
    chk("both_waddr", write_addr, 3);
    chk("both_raddr", read_addr, 0);
    drive(1'b0, 1'b0, '0);
    #1;
    chk("both_count", count, 3);
    chk("both_waddr_nx", write_addr, 4);
    chk("both_raddr_nx", read_addr, 1);
    chk("both_rdata", rdata, 10'h11);
    chk("both_err", error, 0);

    // Interleaved traffic crossing the 7->0 wrap on both pointers.
    for (int i = 0; i < 12; i++) begin
      drive(1'b1, 1'b0, W'(10'h100 + i));
      drive(1'b0, 1'b1, '0);
    end
    drive(1'b0, 1'b0, '0);
    #1;
    chk("wrap_count", count, 3);
    chk("wrap_raddr", read_addr, 5);
    chk("wrap_waddr", write_addr, 0);
    chk("wrap_rdata", rdata, 10'h108);

    // Mid-cycle reset at count 5 with error and data_valid both set beforehand.
    do_reset();
    drive(1'b0, 1'b1, '0);
    for (int i = 0; i < 5; i++) drive(1'b1, 1'b0, W'(10'h50 + i));
    drive(1'b1, 1'b1, 10'h55);
    @(posedge clk);
    #2;
    reset_L = 1'b0;
    #1;
    chk("mrst_count", count, 0);
    chk("mrst_empty", empty, 1);
    chk("mrst_aempty", almost_empty, 1);
    chk("mrst_full", full, 0);
    chk("mrst_afull", almost_full, 0);
    chk("mrst_error", error, 0);
    chk("mrst_dvalid", data_valid, 0);
    chk("mrst_we", write_enable, 0);
    chk("mrst_re", read_enable, 0);
    chk("mrst_waddr", write_addr, 0);
    chk("mrst_raddr", read_addr, 0);
    #1;
    reset_L = 1'b1;
    drive(1'b1, 1'b0, 10'h66);
    #1;
    chk("post_rst_we", write_enable, 1);
    drive(1'b0, 1'b0, '0);
    #1;
    chk("post_rst_count", count, 1);

    // Random traffic with shifting bias and occasional reset.
    for (int i = 0; i < 600; i++) begin
      int bias;
      bias = ((i / 50) % 2 == 0) ? 70 : 30;
      if ($urandom_range(0, 199) == 0) do_reset();
      drive($urandom_range(0, 99) < bias, $urandom_range(0, 99) < (100 - bias),
            W'($urandom_range(0, 1023)));
    end
    drive(1'b0, 1'b0, '0);
    repeat (2) @(negedge clk);
    #3;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fifo_ctrl.md
FIFO_CTRL -- requirements
Module: fifo_ctrl

Interface
REQ-001 Parameter MEM_WIDTH, default 10: data word width in bits.
REQ-002 Parameter MEM_LENGTH, default 8: memory depth in words, a power of two.
REQ-003 Parameter AF_TH, default 6: almost_full asserts when count >= AF_TH.
REQ-004 Parameter AE_TH, default 2: almost_empty asserts when count <= AE_TH.
REQ-005 The port list SHALL be:
- clk  in  1  single clock; all state updates on its rising edge.
- reset_L  in  1  asynchronous, active-low reset.
- push  in  1  write request from upstream.
- pop  in  1  read request from downstream.
- data_in  in  MEM_WIDTH  write data from upstream.
- fifo_Data_in  out  MEM_WIDTH  write data to memory.
- write_addr  out  4  memory write address.
- read_addr  out  4  memory read address.
- write_enable  out  1  memory write strobe.
- read_enable  out  1  memory read strobe.
- full  out  1  count == MEM_LENGTH.
- empty  out  1  count == 0.
- almost_full  out  1  count >= AF_TH.
- almost_empty  out  1  count <= AE_TH.
- count  out  4  occupancy, 0..MEM_LENGTH.
- data_valid  out  1  memory read data is valid this cycle.
- error  out  1  sticky overflow/underflow flag.

Function
REQ-006 The block SHALL act as the initiator of the dual-port memory protocol, generating all addresses and strobes for a memory that writes on the clk edge when write_enable is high and registers read data on the clk edge when read_enable is high.
REQ-007 Accept rules:
- push_ok = push & ~full.
- pop_ok = pop & ~empty.
- Both are evaluated against the registered full and empty flags.
REQ-008 Combinational memory drive:
- write_enable = push_ok; read_enable = pop_ok.
- fifo_Data_in = data_in.
- write_addr = {0, wr_ptr}; read_addr = {0, rd_ptr}.
REQ-009 Pointers:
- wr_ptr and rd_ptr are 3 bits for the default depth.
- Each increments by 1 on push_ok or pop_ok respectively.
- Each wraps from MEM_LENGTH-1 to 0 with no other side effect.
REQ-010 Count update per cycle:
- +1 on push_ok only.
- -1 on pop_ok only.
- Unchanged when both are accepted or neither is.
- Count never leaves 0..MEM_LENGTH.
REQ-011 full, empty, almost_full and almost_empty SHALL be decoded from the registered count only, with no combinational path from push or pop.
REQ-012 Push and pop while empty: the push is accepted, the pop is rejected, and error is set.
REQ-013 Push and pop while full: the pop is accepted, the push is rejected, and error is set.
REQ-014 Push and pop in any other state: both are accepted in the same cycle and count is unchanged.
REQ-015 A push while full, or a pop while empty, SHALL:
- set error on the next edge;
- leave pointers, count and memory unchanged.
REQ-016 error SHALL stay high until reset; it is never cleared by traffic.
REQ-017 data_valid SHALL be a register loaded with pop_ok, so it is high exactly one cycle after each accepted pop, aligned with the memory read data.
REQ-018 Data order SHALL be strict FIFO; the k-th accepted pop returns the k-th accepted push.

Reset
REQ-019 When reset_L is low, asynchronously and regardless of clk:
- wr_ptr, rd_ptr and count = 0;
- empty = 1, almost_empty = 1;
- full = 0, almost_full = 0;
- error = 0, data_valid = 0;
- write_enable = 0, read_enable = 0.
REQ-020 Reset asserted mid-operation SHALL discard all occupancy; memory contents are not cleared but are unreachable.
REQ-021 After reset_L deasserts, the first rising clk edge SHALL accept requests normally.

Verification
REQ-022 The bench SHALL cover these directed scenarios:
- Reset then 8 pushes of 0x001..0x008 -> write_addr 0..7; count 8; full=1; almost_full from count 6; empty=0; error=0.
- 9th push while full -> write_enable=0; count stays 8; error=1 next cycle.
- 8 pops after the fill -> read_addr 0..7; data_valid one cycle after each read_enable; data 0x001..0x008 in order; empty=1 at the end.
- Pop on empty after reset -> read_enable=0; count 0; error=1.
- Push and pop in the same cycle at count 3 -> both strobes high; count stays 3; pointers each advance by 1.
- 12 pushes interleaved with 12 pops, crossing address 7->0 -> read_addr wraps 7->0 and data order is preserved.
- reset_L pulsed low mid-cycle at count 5 -> all outputs take reset values immediately, before the next clk edge.
